pc_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer for the 16-bit datapath.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/fetch_timeout_ctr.sv | 55 +++++
 rtl/pc_fetch_unit.sv | 134 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and fetch-state encoding for the 16-bit
//                datapath front end.
//                Contents:
//                  CPU_WIDTH, CPU_RESET_PC    default datapath width and reset PC
//                  fetch_state_t              2-bit fetch state type
//                  FETCH / HOLD / EXEC        legal states; 2'd3 is illegal and
//                                             recovers to FETCH
//                  is_redirect()              flush+pcWrite qualifier
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int          CPU_WIDTH    = 16;
   localparam logic [15:0] CPU_RESET_PC = 16'h0000;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t FETCH   = 2'd0;
   localparam fetch_state_t HOLD    = 2'd1;
   localparam fetch_state_t EXEC    = 2'd2;
   localparam fetch_state_t ILLEGAL = 2'd3;

   // A flush only takes effect when it carries a new PC with it.
   function automatic logic is_redirect(input logic flush, input logic pc_write);
      return flush & pc_write;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_timeout_ctr
//  Description : Wait-cycle counter for an outstanding instruction fetch with a
//                sticky fault flag. Counts cycles where inc is high, clears on
//                clr, saturates at LIMIT and raises fault on the cycle the
//                count reaches LIMIT. The fault holds until reset.
//  Parameters  : LIMIT  number of waiting cycles that trigger the fault
//  Ports       : clk    clock, rising edge
//                reset  synchronous, active-high
//                inc    fetch cycle without acknowledge
//                clr    fetch completed, abandoned or not fetching
//                fault  sticky timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_timeout_ctr #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic fault
);

   // At least one bit even for a degenerate LIMIT of zero.
   localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

   localparam logic [CW:0] c_limit_ext = (CW + 1)'(LIMIT);

   logic [CW-1:0] r_count;
   logic          r_fault;
   logic [CW:0]   w_count_next;

   // One extra bit so the incremented value never wraps before the compare.
   assign w_count_next = {1'b0, r_count} + {{CW{1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
         r_fault <= 1'b0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc) begin
         if (w_count_next <= c_limit_ext)
            r_count <= w_count_next[CW-1:0];
         if (w_count_next >= c_limit_ext)
            r_fault <= 1'b1;
      end
   end

   assign fault = r_fault;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Program-counter register and instruction-fetch sequencer.
//                Holds the architectural PC, reads the instruction at PC from
//                instruction memory and presents it to decode over a
//                valid/ready handshake. The PC is loaded verbatim from pcNext
//                when control commits (no adder lives here).
//  Build macro : FETCH_TIMEOUT_EN - when defined, a memAck wait counter drives
//                a sticky fetchFault after TIMEOUT_CYC waiting cycles; when not
//                defined fetchFault is tied low.
//  Parameters  : WIDTH        PC / address / instruction width
//                RESET_PC     PC value loaded on reset
//                TIMEOUT_CYC  memAck wait limit (FETCH_TIMEOUT_EN only)
//  Ports       : clk, reset          clock, synchronous active-high reset
//                pcNext, pcWrite     next PC from PC ALU and commit strobe
//                flush               abandon current fetch/instr (with pcWrite)
//                pc                  current PC to PC ALU
//                memAddr, memReq     instruction memory request (addr == pc)
//                memRdata, memAck    instruction memory response
//                instr, instrValid   instruction register to decode
//                instrReady          decode accepts instr
//                fetchFault          sticky fetch timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                WIDTH       = CPU_WIDTH,
   parameter logic [WIDTH-1:0]  RESET_PC    = WIDTH'(CPU_RESET_PC),
   parameter int                TIMEOUT_CYC = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pcNext,
   input  logic             pcWrite,
   input  logic             flush,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] memAddr,
   output logic             memReq,
   input  logic [WIDTH-1:0] memRdata,
   input  logic             memAck,
   output logic [WIDTH-1:0] instr,
   output logic             instrValid,
   input  logic             instrReady,
   output logic             fetchFault
);

   fetch_state_t     r_state;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_instr;
   logic             w_redirect;

   assign w_redirect = is_redirect(flush, pcWrite);

   // ------------------------------------------------------------------------
   // Fetch FSM with PC and instruction registers. A redirect outranks every
   // state action, so a memAck arriving in the same cycle is dropped and the
   // instruction register keeps its old contents.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= FETCH;
         r_pc    <= RESET_PC;
         r_instr <= '0;
      end else if (w_redirect) begin
         r_state <= FETCH;
         r_pc    <= pcNext;
      end else begin
         case (r_state)
            FETCH: begin
               if (memAck) begin
                  r_instr <= memRdata;
                  r_state <= HOLD;
               end
            end
            HOLD: begin
               // Commit in the same cycle as the handoff skips EXEC.
               if (instrReady) begin
                  if (pcWrite) begin
                     r_pc    <= pcNext;
                     r_state <= FETCH;
                  end else begin
                     r_state <= EXEC;
                  end
               end
            end
            EXEC: begin
               if (pcWrite) begin
                  r_pc    <= pcNext;
                  r_state <= FETCH;
               end
            end
            default: r_state <= FETCH;
         endcase
      end
   end

   assign pc         = r_pc;
   assign memAddr    = r_pc;
   assign instr      = r_instr;
   assign memReq     = (r_state == FETCH);
   assign instrValid = (r_state == HOLD);

   // ------------------------------------------------------------------------
   // Optional fetch timeout. The counter runs only on FETCH cycles still
   // waiting for memAck; any other cycle (ack, redirect, other state) restarts
   // it. After a fault the FSM keeps requesting, so a late ack still works.
   // ------------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
   logic w_ctr_inc;
   logic w_ctr_clr;

   assign w_ctr_inc = (r_state == FETCH) && !memAck && !w_redirect;
   assign w_ctr_clr = !w_ctr_inc;

   fetch_timeout_ctr #(
      .LIMIT (TIMEOUT_CYC)
   ) u_fetch_timeout_ctr (
      .clk   (clk),
      .reset (reset),
      .inc   (w_ctr_inc),
      .clr   (w_ctr_clr),
      .fault (fetchFault)
   );
`else
   logic w_unused_timeout;

   assign w_unused_timeout = ^TIMEOUT_CYC;
   assign fetchFault       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_unit
//  Description : Randomized self-checking bench for pc_fetch_unit. A driver
//                walks a program of instructions (fetch with random ack delay,
//                random hold, handoff with or without same-cycle commit, exec
//                wait, commit) while a behavioural model tracks the PC. Each
//                acknowledged fetch pushes the expected {addr, data} onto a
//                scoreboard; a monitor pops it when decode accepts an instr.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

   localparam int NUM_INSTR = 40;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pcNext;
   logic        pcWrite;
   logic        flush;
   logic [15:0] pc;
   logic [15:0] memAddr;
   logic        memReq;
   logic [15:0] memRdata;
   logic        memAck;
   logic [15:0] instr;
   logic        instrValid;
   logic        instrReady;
   logic        fetchFault;

   always #5 clk = ~clk;

   pc_fetch_unit #(
      .WIDTH       (16),
      .RESET_PC    (16'h0000),
      .TIMEOUT_CYC (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pcNext     (pcNext),
      .pcWrite    (pcWrite),
      .flush      (flush),
      .pc         (pc),
      .memAddr    (memAddr),
      .memReq     (memReq),
      .memRdata   (memRdata),
      .memAck     (memAck),
      .instr      (instr),
      .instrValid (instrValid),
      .instrReady (instrReady),
      .fetchFault (fetchFault)
   );

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] model_pc;
   logic [15:0] last_instr;
   bit          fault_phase = 1'b0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted handoff.
   always @(negedge clk) begin
      if (!reset && !fault_phase)
         chk("fault_idle", {15'd0, fetchFault}, 16'd0);
      if (!reset && instrValid === 1'b1 && instrReady === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_handoff: got instr %h expected no handoff", instr);
         end else begin
            mon_e = sbq.pop_front();
            chk("handoff_instr", instr, mon_e.data);
            chk("handoff_pc", pc, mon_e.addr);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pcWrite    = 1'b0;
      flush      = 1'b0;
      instrReady = 1'b0;
      memAck     = 1'b0;
      memRdata   = 16'($urandom);
      pcNext     = 16'($urandom);
   endtask

   // Fetch until an ack is accepted; a redirect restarts the fetch at pcNext.
   task automatic do_fetch(input int i);
      bit done;
      bit ack;
      bit fl;
      int d;
      done = 1'b0;
      while (!done) begin
         d = (i == 0) ? 0 : int'($urandom_range(0, 3));
         for (int c = 0; c <= d; c++) begin
            ack        = (c == d);
            fl         = ack && (i > 2) && ($urandom_range(0, 9) == 0);
            memAck     = ack;
            memRdata   = 16'($urandom);
            instrReady = 1'($urandom);
            pcNext     = 16'($urandom);
            if (fl) begin
               flush   = 1'b1;
               pcWrite = 1'b1;
            end else begin
               pcWrite = 1'($urandom);
               flush   = pcWrite ? 1'b0 : 1'($urandom);
            end
            @(negedge clk);
            if (i == 0 && c == 0) begin
               chk("reset_pc", pc, 16'h0000);
               chk("reset_instr", instr, 16'h0000);
            end
            chk("fetch_memReq", {15'd0, memReq}, 16'd1);
            chk("fetch_memAddr", memAddr, model_pc);
            chk("fetch_instrValid", {15'd0, instrValid}, 16'd0);
            chk("fetch_instr_stable", instr, last_instr);
            if (fl) begin
               model_pc = pcNext;
            end else if (ack) begin
               sbq.push_back('{addr: model_pc, data: memRdata});
               last_instr = memRdata;
               done = 1'b1;
            end
            next_cycle();
            if (fl) break;
         end
      end
   endtask

   task automatic run_instr(input int i);
      logic [15:0] nxt;
      bit          combine;
      int          k;
      int          j;
      case (i)
         0:       nxt = 16'h0001;
         1:       nxt = 16'hFFFF;
         2:       nxt = 16'h0000;
         default: nxt = 16'($urandom);
      endcase
      do_fetch(i);
      // HOLD without ready; pcWrite without flush must be ignored.
      k = int'($urandom_range(0, 3));
      for (int c = 0; c < k; c++) begin
         instrReady = 1'b0;
         memAck     = 1'($urandom);
         memRdata   = 16'($urandom);
         pcWrite    = 1'($urandom);
         flush      = pcWrite ? 1'b0 : 1'($urandom);
         pcNext     = 16'($urandom);
         @(negedge clk);
         chk("hold_instrValid", {15'd0, instrValid}, 16'd1);
         chk("hold_memReq", {15'd0, memReq}, 16'd0);
         chk("hold_instr", instr, last_instr);
         chk("hold_pc", pc, model_pc);
         next_cycle();
      end
      // Handoff.
      combine    = (i == 0) ? 1'b1 : 1'($urandom);
      instrReady = 1'b1;
      memAck     = 1'($urandom);
      flush      = 1'b0;
      pcWrite    = combine;
      pcNext     = nxt;
      @(negedge clk);
      chk("accept_instrValid", {15'd0, instrValid}, 16'd1);
      next_cycle();
      if (combine) begin
         model_pc = nxt;
         return;
      end
      // EXEC wait, then commit.
      j = int'($urandom_range(0, 2));
      for (int c = 0; c < j; c++) begin
         instrReady = 1'($urandom);
         memAck     = 1'($urandom);
         pcWrite    = 1'b0;
         flush      = 1'($urandom);
         pcNext     = 16'($urandom);
         @(negedge clk);
         chk("exec_instrValid", {15'd0, instrValid}, 16'd0);
         chk("exec_memReq", {15'd0, memReq}, 16'd0);
         chk("exec_pc", pc, model_pc);
         next_cycle();
      end
      pcWrite    = 1'b1;
      flush      = 1'($urandom);
      instrReady = 1'($urandom);
      pcNext     = nxt;
      @(negedge clk);
      chk("commit_instrValid", {15'd0, instrValid}, 16'd0);
      next_cycle();
      model_pc = nxt;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      reset      = 1'b0;
      model_pc   = 16'h0000;
      last_instr = 16'h0000;

      for (int i = 0; i < NUM_INSTR; i++)
         run_instr(i);

      // Reset while in EXEC.
      idle_inputs();
      memAck   = 1'b1;
      memRdata = 16'h1234;
      @(negedge clk);
      sbq.push_back('{addr: model_pc, data: 16'h1234});
      next_cycle();
      idle_inputs();
      instrReady = 1'b1;
      next_cycle();
      idle_inputs();
      @(negedge clk);
      chk("exec_before_reset", {15'd0, instrValid}, 16'd0);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_exec_pc", pc, 16'h0000);
      chk("rst_exec_instrValid", {15'd0, instrValid}, 16'd0);
      chk("rst_exec_memReq", {15'd0, memReq}, 16'd1);
      chk("rst_exec_instr", instr, 16'h0000);
      chk("scoreboard_drained", 16'(sbq.size()), 16'd0);

`ifdef FETCH_TIMEOUT_EN
      // Timeout after four waiting cycles, sticky through a late ack.
      reset       = 1'b1;
      next_cycle();
      fault_phase = 1'b1;
      reset       = 1'b0;
      idle_inputs();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("timeout_pending", {15'd0, fetchFault}, 16'd0);
         next_cycle();
      end
      memAck   = 1'b1;
      memRdata = 16'hA5A5;
      @(negedge clk);
      chk("timeout_fault", {15'd0, fetchFault}, 16'd1);
      chk("timeout_memReq", {15'd0, memReq}, 16'd1);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      chk("timeout_late_ack_valid", {15'd0, instrValid}, 16'd1);
      chk("timeout_late_ack_instr", instr, 16'hA5A5);
      chk("timeout_sticky", {15'd0, fetchFault}, 16'd1);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk("timeout_reset_clears", {15'd0, fetchFault}, 16'd0);
      fault_phase = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
